// File: rtl/bmc_decoder_pkg.sv
// Shared definitions for the biphase-mark decoder: default sizes, timing
// thresholds, FSM state encoding and the interval classifier.
package bmc_decoder_pkg;

  localparam int   NB_BITS_DEF    = 17;
  localparam int   TS_WIDTH_DEF   = 24;
  localparam int   SHORT_MIN_DEF  = 4;
  localparam int   SHORT_MAX_DEF  = 11;
  localparam int   LONG_MAX_DEF   = 20;
  localparam logic ENV_ACTIVE_DEF = 1'b0;

  // Interval counter width; comfortably holds LONG_MAX+1 for any sane threshold.
  localparam int IV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT_END = 3'd4
  } bmc_state_t;

  typedef enum logic [1:0] {
    IV_SHORT = 2'd0,
    IV_LONG  = 2'd1,
    IV_BAD   = 2'd2
  } ival_class_t;

  // Classify the clock count between two data edges as half-bit, full-bit or invalid.
  function automatic ival_class_t classify_ival(input logic [IV_W-1:0] ival,
                                                input logic            sat,
                                                input int              smin,
                                                input int              smax,
                                                input int              lmax);
    int v;
    v = int'(ival);
    if (sat || v < smin) return IV_BAD;
    if (v <= smax)       return IV_SHORT;
    if (v <= lmax)       return IV_LONG;
    return IV_BAD;
  endfunction

endpackage

// File: rtl/bmc_decoder_sync.sv
// Two-flop synchroniser with a registered copy for edge detection.
// The flops carry no reset: a decoder reset must not fake an envelope
// transition, so the synchronised levels always track the real pins.
module sync_edge_detector (
  input  logic clk,
  input  logic i_async,
  output logic o_level,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability stage, stable stage, and one-cycle-old copy for the edge XOR.
  always_ff @(posedge clk) begin
    r_meta <= i_async;
    r_sync <= r_meta;
    r_prev <= r_sync;
  end

  assign o_level = r_sync;
  assign o_edge  = r_sync ^ r_prev;

endmodule

// File: rtl/bmc_decoder.sv
// Biphase-mark decoder for one photodiode channel. Captures the first
// NB_BITS bits of a sweep pulse plus the timestamp of its first data edge.
//
// Output handshake: data_availible is a level-valid flag. When it rises,
// decoded_data and ts_data are already stable and stay stable for as long as
// it is high. There is no ready input; the consumer acknowledges by pulsing
// reset for one cycle, which clears the word and the flag on the next edge.
module bmc_decoder
  import bmc_decoder_pkg::*;
#(
  parameter int   NB_BITS    = NB_BITS_DEF,
  parameter int   TS_WIDTH   = TS_WIDTH_DEF,
  parameter int   SHORT_MIN  = SHORT_MIN_DEF,
  parameter int   SHORT_MAX  = SHORT_MAX_DEF,
  parameter int   LONG_MAX   = LONG_MAX_DEF,
  parameter logic ENV_ACTIVE = ENV_ACTIVE_DEF
) (
  input  logic                clk_96MHz,
  input  logic                reset,
  input  logic                sensor_e,
  input  logic                sensor_d,
  input  logic [TS_WIDTH-1:0] timestamp,
  output logic [NB_BITS-1:0]  decoded_data,
  output logic [TS_WIDTH-1:0] ts_data,
  output logic                data_availible,
  output bmc_state_t          o_dbg_state
);

  localparam int BC_W = $clog2(NB_BITS + 1);

  logic              w_d_edge;
  logic              w_unused_d_level;
  logic              w_e_level;
  logic              w_unused_e_edge;
  logic              w_env_act;
  logic              w_sat;
  logic [IV_W-1:0]   w_ival;
  ival_class_t       w_class;

  bmc_state_t        r_state;
  bmc_state_t        w_state_nx;
  logic [IV_W-1:0]   r_interval;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [BC_W-1:0]   w_bit_cnt_nx;
  logic              r_half;
  logic              w_half_nx;
  logic [NB_BITS-1:0] r_shreg;
  logic [NB_BITS-1:0] w_shreg_nx;
  logic [TS_WIDTH-1:0] r_ts_cap;
  logic              w_cap_ts;
  logic              w_load_out;
  logic              r_off_seen;
  logic [NB_BITS-1:0]  r_decoded;
  logic [TS_WIDTH-1:0] r_ts_out;
  logic                r_valid;

  sync_edge_detector u_sync_d (
    .clk     (clk_96MHz),
    .i_async (sensor_d),
    .o_level (w_unused_d_level),
    .o_edge  (w_d_edge)
  );

  sync_edge_detector u_sync_e (
    .clk     (clk_96MHz),
    .i_async (sensor_e),
    .o_level (w_e_level),
    .o_edge  (w_unused_e_edge)
  );

  assign w_env_act = (w_e_level == ENV_ACTIVE);
  // Interval in clocks between the previous edge and the current one.
  assign w_sat     = (r_interval == IV_W'(LONG_MAX + 1));
  assign w_ival    = r_interval + IV_W'(1);
  assign w_class   = classify_ival(w_ival, w_sat, SHORT_MIN, SHORT_MAX, LONG_MAX);

  // Next-state and datapath decisions; every output defaults to "hold".
  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_half_nx    = r_half;
    w_shreg_nx   = r_shreg;
    w_cap_ts     = 1'b0;
    w_load_out   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_off_seen blocks re-triggering in the middle of a pulse after reset.
        if (w_env_act && r_off_seen) w_state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        if (!w_env_act) begin
          w_state_nx = ST_IDLE;
        end else if (w_d_edge) begin
          w_cap_ts     = 1'b1;
          w_bit_cnt_nx = '0;
          w_half_nx    = 1'b0;
          w_state_nx   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // A finished word wins over an envelope drop seen on the same cycle.
        if (r_bit_cnt == BC_W'(NB_BITS)) begin
          w_load_out = 1'b1;
          w_state_nx = ST_HOLD;
        end else if (w_d_edge) begin
          case (w_class)
            IV_SHORT: begin
              if (!r_half) begin
                w_half_nx = 1'b1;
              end else begin
                w_shreg_nx   = {r_shreg[NB_BITS-2:0], 1'b1};
                w_half_nx    = 1'b0;
                w_bit_cnt_nx = r_bit_cnt + BC_W'(1);
              end
            end
            IV_LONG: begin
              if (!r_half) begin
                w_shreg_nx   = {r_shreg[NB_BITS-2:0], 1'b0};
                w_bit_cnt_nx = r_bit_cnt + BC_W'(1);
              end else begin
                w_state_nx = ST_WAIT_END;
              end
            end
            default: w_state_nx = ST_WAIT_END;
          endcase
        end else if (!w_env_act) begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_state_nx = ST_HOLD;
      end
      ST_WAIT_END: begin
        if (!w_env_act) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State, counters, shift register and output word registers.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_interval <= '0;
      r_bit_cnt  <= '0;
      r_half     <= 1'b0;
      r_shreg    <= '0;
      r_ts_cap   <= '0;
      r_off_seen <= 1'b0;
      r_decoded  <= '0;
      r_ts_out   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_half    <= w_half_nx;
      r_shreg   <= w_shreg_nx;
      if (!w_env_act) r_off_seen <= 1'b1;
      if (w_d_edge) r_interval <= '0;
      else if (!w_sat) r_interval <= r_interval + IV_W'(1);
      if (w_cap_ts) r_ts_cap <= timestamp;
      if (w_load_out) begin
        r_decoded <= r_shreg;
        r_ts_out  <= r_ts_cap;
        r_valid   <= 1'b1;
      end
    end
  end

  assign decoded_data   = r_decoded;
  assign ts_data        = r_ts_out;
  assign data_availible = r_valid;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bmc_decoder.sv
// Bench for bmc_decoder: directed BMC pulses driven on the falling clock
// edge, expected words queued by the stimulus and checked by a monitor
// that fires on each rising data_availible.
module tb_bmc_decoder;
  import bmc_decoder_pkg::*;

  localparam int NB = 17;
  localparam int TW = 24;
  localparam int W  = NB + TW;

  logic          clk = 1'b0;
  logic          reset;
  logic          sensor_e;
  logic          sensor_d;
  logic [TW-1:0] timestamp;
  logic [NB-1:0] decoded_data;
  logic [TW-1:0] ts_data;
  logic          data_availible;
  bmc_state_t    dbg_state;

  logic          ts_load;
  logic [TW-1:0] ts_load_val;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          prev_valid = 1'b0;

  bmc_decoder dut (
    .clk_96MHz      (clk),
    .reset          (reset),
    .sensor_e       (sensor_e),
    .sensor_d       (sensor_d),
    .timestamp      (timestamp),
    .decoded_data   (decoded_data),
    .ts_data        (ts_data),
    .data_availible (data_availible),
    .o_dbg_state    (dbg_state)
  );

  // Clock and free-running timestamp (loadable so a test can pin its value).
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ts_load) timestamp <= ts_load_val;
    else         timestamp <= timestamp + 24'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each new word is compared with the oldest expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (data_availible === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {47'd0, decoded_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("word_data", {47'd0, decoded_data}, {47'd0, e[W-1:TW]});
        check("word_ts", {40'd0, ts_data}, {40'd0, e[TW-1:0]});
      end
    end
    prev_valid = data_availible;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle_after(input int n);
    wait_clk(n);
    sensor_d = ~sensor_d;
  endtask

  // First edge then nbits BMC bit cells, MSB first; returns timestamp seen at the first edge.
  task automatic drive_bits(input logic [NB-1:0] word, input int nbits, input bit jit,
                            input bit preload, output logic [TW-1:0] first_ts);
    int h1;
    int h2;
    int f;
    if (preload) begin
      ts_load_val = 24'h001232;
      ts_load     = 1'b1;
    end
    wait_clk(1);
    ts_load  = 1'b0;
    first_ts = timestamp;
    sensor_d = ~sensor_d;
    for (int i = 0; i < nbits; i++) begin
      if (jit) begin
        h1 = (i % 2 == 0) ? 6 : 10;
        h2 = 16 - h1;
        f  = (i % 2 == 0) ? 14 : 19;
      end else begin
        h1 = 8;
        h2 = 8;
        f  = 16;
      end
      if (word[NB-1-i]) begin
        toggle_after(h1);
        toggle_after(h2);
      end else begin
        toggle_after(f);
      end
    end
  endtask

  task automatic env_on();
    sensor_e = 1'b0;
    wait_clk(20);
  endtask

  task automatic env_off();
    wait_clk(10);
    sensor_e = 1'b1;
    wait_clk(20);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
  endtask

  // Full pulse with a queued expectation, then consumer clear and envelope drop.
  task automatic full_pulse(input logic [NB-1:0] word, input bit jit, input string name);
    logic [TW-1:0] t0;
    env_on();
    drive_bits(word, NB, jit, 1'b0, t0);
    exp_q.push_back({word, t0 + 24'd2});
    wait_clk(8);
    pulse_reset();
    check(name, {63'd0, data_availible}, 64'd0);
    env_off();
  endtask

  initial begin
    logic [TW-1:0] t0;
    int bad;
    reset       = 1'b1;
    sensor_e    = 1'b1;
    sensor_d    = 1'b0;
    ts_load     = 1'b1;
    ts_load_val = 24'd0;
    wait_clk(6);
    ts_load = 1'b0;
    check("rst_data", {47'd0, decoded_data}, 64'd0);
    check("rst_ts", {40'd0, ts_data}, 64'd0);
    check("rst_valid", {63'd0, data_availible}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    reset = 1'b0;
    wait_clk(10);

    // Test 1: nominal pulse, pinned timestamp, 4-clock latency.
    env_on();
    drive_bits(17'h0D275, NB, 1'b0, 1'b1, t0);
    exp_q.push_back({17'h0D275, 24'h001234});
    wait_clk(3);
    check("latency_early", {63'd0, data_availible}, 64'd0);
    wait_clk(1);
    check("latency_4clk", {63'd0, data_availible}, 64'd1);

    // Test 2: hold for 500 clocks while more edges arrive, then consume.
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      wait_clk(1);
      if (k < 200 && k % 8 == 0) sensor_d = ~sensor_d;
      if (decoded_data !== 17'h0D275 || ts_data !== 24'h001234 || data_availible !== 1'b1) bad++;
    end
    check("hold_stable", 64'(bad), 64'd0);
    pulse_reset();
    check("consume_data", {47'd0, decoded_data}, 64'd0);
    check("consume_ts", {40'd0, ts_data}, 64'd0);
    check("consume_valid", {63'd0, data_availible}, 64'd0);
    check("consume_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    for (int k = 0; k < 20; k++) toggle_after(8);
    check("post_consume_idle", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    env_off();

    // Test 3: envelope drops after 10 bits, then a full all-ones pulse.
    env_on();
    drive_bits(17'h0D275, 10, 1'b0, 1'b0, t0);
    env_off();
    check("abort_valid", {63'd0, data_availible}, 64'd0);
    check("abort_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    full_pulse(17'h1FFFF, 1'b0, "clear_ones");

    // Test 4: 30-clock gap at bit 5, then a full all-zeros pulse.
    env_on();
    drive_bits(17'h15555, 5, 1'b0, 1'b0, t0);
    toggle_after(30);
    wait_clk(5);
    check("gap_wait_end", {61'd0, dbg_state}, {61'd0, ST_WAIT_END});
    for (int k = 0; k < 12; k++) toggle_after(8);
    env_off();
    check("gap_valid", {63'd0, data_availible}, 64'd0);
    full_pulse(17'h00000, 1'b0, "clear_zeros");

    // Test 5: pending half followed by a full interval, then jittered pulse.
    env_on();
    wait_clk(1);
    sensor_d = ~sensor_d;
    toggle_after(16);
    toggle_after(8);
    toggle_after(16);
    wait_clk(5);
    check("short_long_err", {61'd0, dbg_state}, {61'd0, ST_WAIT_END});
    env_off();
    check("short_long_valid", {63'd0, data_availible}, 64'd0);
    full_pulse(17'h0A5C3, 1'b1, "clear_jitter");

    // Test 6: reset at bit 9 with envelope still active; no re-trigger until it drops.
    env_on();
    drive_bits(17'h1B4E9, 9, 1'b0, 1'b0, t0);
    pulse_reset();
    check("mid_rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("mid_rst_valid", {63'd0, data_availible}, 64'd0);
    drive_bits(17'h1B4E9, NB, 1'b0, 1'b0, t0);
    wait_clk(10);
    check("rearm_blocked_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("rearm_blocked_valid", {63'd0, data_availible}, 64'd0);
    env_off();
    full_pulse(17'h1B4E9, 1'b0, "clear_rearm");

    wait_clk(20);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
